// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
// Shared definitions for the round-robin 4:1 stream mux and its matching
// 1:4 demux. Both ends agree on the channel count and the width of the
// source tag that travels with every beat.
//   N_CH     : number of channels on the fan-in / fan-out side
//   SEL_W    : width of the channel tag (out_sel on the mux)
//   ch_sel_t : channel index / tag type
package rr_mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Purely combinational rotating-priority arbiter for four requesters.
// Scanning starts at ptr and wraps, so the requester just after the last
// winner gets first chance next time.
//   req        in  [3:0]  request vector
//   ptr        in  [1:0]  highest-priority requester this cycle
//   gnt_onehot out [3:0]  one-hot grant, zero when nobody requests
//   gnt_idx    out [1:0]  index of the granted requester (0 when none)
//   any_gnt    out        at least one requester was granted
module rr_arbiter4
  import rr_mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_sel_t         ptr,
  output logic [N_CH-1:0] gnt_onehot,
  output ch_sel_t         gnt_idx,
  output logic            any_gnt
);

  ch_sel_t cand;

  // Walk ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps naturally, and the
  // first requester found locks out the rest of the scan.
  always_comb begin
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    cand       = '0;
    gnt_onehot = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = ptr + ch_sel_t'(k);
      if (!any_gnt && req[cand]) begin
        gnt_idx = cand;
        any_gnt = 1'b1;
      end
    end
    if (any_gnt) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux4.sv
// rr_mux4
// Four-to-one round-robin stream multiplexer with one registered output
// stage. Each output beat is tagged with its source channel so the far-end
// demux can route it back.
//   WIDTH     param      data width per beat (default 8)
//   clk       in         rising-edge clock
//   rst       in         synchronous active-high reset
//   in_data   in  4*W    channel i data on [i*WIDTH +: WIDTH]
//   in_valid  in  [3:0]  channel i offers a beat
//   in_ready  out [3:0]  channel i beat accepted this cycle (one-hot or zero)
//   out_data  out [W]    registered beat data
//   out_sel   out [1:0]  source channel of the current output beat
//   out_valid out        output register holds a beat
//   out_ready in         downstream takes the beat
module rr_mux4
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  ch_sel_t           ptr;
  ch_sel_t           gnt_idx;
  logic [N_CH-1:0]   gnt_onehot;
  logic              any_gnt;
  logic              load;
  logic [WIDTH-1:0]  ch_data [N_CH];
  logic [WIDTH-1:0]  win_data;

  rr_arbiter4 u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  // Register can take a new beat when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // Slice the flat input bus into per-channel words and pick the winner's.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
    win_data = ch_data[gnt_idx];
  end

  // Grant only reaches a channel when the register can load, and never
  // during reset so a beat offered in the reset cycle is not consumed.
  // gnt_onehot only ever contains requesting channels.
  assign in_ready = (load && !rst) ? gnt_onehot : '0;

  // Output register and priority pointer. With no winner the register
  // empties but keeps its last data/tag and the pointer stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= gnt_idx;
        ptr       <= gnt_idx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4
// Directed bench for rr_mux4 (WIDTH = 8). Inputs change 1 time unit after
// the rising edge; in_ready and the registered outputs are compared 2 units
// later, well away from the next edge. Expected values are worked out by
// hand from the round-robin rules and written inline.
module tb_rr_mux4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  logic [7:0] chan_data [4];

  rr_mux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the inputs for the coming edge and let combinational logic settle.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic ordy);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    #2;
  endtask

  // Compare only the combinational ready vector.
  task automatic checkReady(input string tag, input logic [3:0] er);
    checks++;
    assert (in_ready === er) else begin
      errors++;
      $error("[TB] FAIL %s in_ready got %b want %b", tag, in_ready, er);
    end
  endtask

  // Compare registered outputs plus in_ready for the current inputs.
  task automatic checkOutput(input string tag, input logic ev, input logic [1:0] es,
                             input logic [7:0] ed, input logic [3:0] er);
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("[TB] FAIL %s out_valid got %b want %b", tag, out_valid, ev);
    end
    checks++;
    assert (out_sel === es) else begin
      errors++;
      $error("[TB] FAIL %s out_sel got %0d want %0d", tag, out_sel, es);
    end
    checks++;
    assert (out_data === ed) else begin
      errors++;
      $error("[TB] FAIL %s out_data got %h want %h", tag, out_data, ed);
    end
    checkReady(tag, er);
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chan_data[0] = 8'hA0;
    chan_data[1] = 8'hB1;
    chan_data[2] = 8'hC2;
    chan_data[3] = 8'hD3;
    in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #1;

    // Reset cycle: even with every input valid nothing is accepted.
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkReady("rst_ready", 4'b0000);
    tick();

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("idle", 1'b0, 2'd0, 8'h00, 4'b0000);
      tick();
    end

    // All channels valid, drain every cycle: grants rotate 0,1,2,3,0,...
    // Before edge i the pointer is i%4; the register shows the beat of edge i-1.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      if (i == 0)
        checkOutput("rr_all", 1'b0, 2'd0, 8'h00, 4'b0001);
      else
        checkOutput("rr_all", 1'b1, 2'((i - 1) % 4), chan_data[(i - 1) % 4],
                    4'(1 << (i % 4)));
      tick();
    end

    // Only channel 2 valid with data 5A. Register shows D3 from ch3, ptr = 0.
    in_data = {8'hD3, 8'h5A, 8'hB1, 8'hA0};
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("ch2_first", 1'b1, 2'd3, 8'hD3, 4'b0100);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("ch2_only", 1'b1, 2'd2, 8'h5A, 4'b0100);
      tick();
    end

    // ptr = 3 after the ch2 grant; channels 0 and 3 valid: ch3 then ch0.
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("wrap_ch3", 1'b1, 2'd2, 8'h5A, 4'b1000);
    tick();
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("wrap_ch0", 1'b1, 2'd3, 8'hD3, 4'b0001);
    tick();
    // Nothing valid: register empties, data/tag hold, ptr stays at 1.
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("wrap_drain", 1'b1, 2'd0, 8'hA0, 4'b0000);
    tick();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("ptr_is_1", 1'b0, 2'd0, 8'hA0, 4'b0010);
    tick();

    // Channel-1 beat stalled 4 cycles with all inputs valid.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput("stall", 1'b1, 2'd1, 8'hB1, 4'b0000);
      tick();
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("release", 1'b1, 2'd1, 8'hB1, 4'b0100);
    tick();
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("after_rel", 1'b1, 2'd2, 8'h5A, 4'b0000);
    tick();

    // Reset while a beat is held and stalled.
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkReady("rst_mid", 4'b0000);
    tick();
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("post_rst", 1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("post_rst_g0", 1'b1, 2'd0, 8'hA0, 4'b0010);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
